// File: rtl/mdio_controller.sv
// mdio_controller: Clause-22 MDIO frame generator with a free-running MDC and read-data capture.
// Define MDIO_PREAMBLE_EN to send 32 preamble ones before each frame.
module mdio_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] T_DATA,
  input  logic        T_STRB,
  input  logic        MDIO_IN,
  output logic        MDC,
  output logic        MDIO_OUT,
  output logic        MDIO_OE,
  output logic [15:0] RD_DATA,
  output logic        DATA_RDY,
  output logic        BUSY
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [2:0] IDLE = 3'd0, SEND = 3'd1, TURN = 3'd2, READ = 3'd3, DONE = 3'd4, PRE = 3'd5;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          fall, rise, rd;
  logic [2:0]    st;
  logic [31:0]   sh;
  logic [5:0]    bits;
  always_comb begin
    fall    = cnt == CW'(CLK_DIV - 1);
    cnt_nxt = fall ? '0 : cnt + 1'b1;
    rise    = cnt_nxt == CW'(CLK_DIV / 2);
  end
  // Outputs change on the same CLK edge that drops MDC, so they settle a half period before the PHY samples.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt      <= '0;
      MDC      <= 1'b0;
      MDIO_OUT <= 1'b0;
      MDIO_OE  <= 1'b0;
      RD_DATA  <= '0;
      DATA_RDY <= 1'b0;
      BUSY     <= 1'b0;
      st       <= IDLE;
      sh       <= '0;
      bits     <= '0;
      rd       <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      MDC      <= cnt_nxt >= CW'(CLK_DIV / 2);
      DATA_RDY <= 1'b0;
      case (st)
        IDLE: if (T_STRB) begin
          sh   <= T_DATA;
          rd   <= T_DATA[29:28] == 2'b10;
          bits <= '0;
          BUSY <= 1'b1;
`ifdef MDIO_PREAMBLE_EN
          st   <= PRE;
`else
          st   <= SEND;
`endif
        end
`ifdef MDIO_PREAMBLE_EN
        PRE: if (fall) begin
          MDIO_OUT <= 1'b1;
          MDIO_OE  <= 1'b1;
          bits     <= bits == 6'd31 ? 6'd0 : bits + 6'd1;
          st       <= bits == 6'd31 ? SEND : PRE;
        end
`endif
        SEND: if (fall) begin
          if ((rd && bits == 6'd14) || bits == 6'd32) begin
            MDIO_OE  <= 1'b0;
            MDIO_OUT <= 1'b0;
            st       <= bits == 6'd32 ? DONE : TURN;
          end else begin
            MDIO_OUT <= sh[31];
            MDIO_OE  <= 1'b1;
            sh       <= {sh[30:0], 1'b0};
          end
          bits <= bits + 6'd1;
        end
        // Bits 14 and 15 of the frame are the turnaround; the read phase starts at the fall of bit 16.
        TURN: if (fall) begin
          bits <= bits == 6'd16 ? 6'd0 : bits + 6'd1;
          st   <= bits == 6'd16 ? READ : TURN;
        end
        READ: if (rise) begin
          sh   <= {sh[30:0], MDIO_IN};
          bits <= bits + 6'd1;
          if (bits == 6'd15) begin
            RD_DATA  <= {sh[14:0], MDIO_IN};
            DATA_RDY <= 1'b1;
            st       <= DONE;
          end
        end
        DONE: begin
          BUSY <= 1'b0;
          st   <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mdio_controller.md
Name: mdio_controller

Overview:
- MDIO management-side (STA) frame generator: sits directly upstream of the PHY-side MDIO receiver and produces the MDC/MDIO_OUT/MDIO_OE stream that the receiver consumes.
- Accepts one 32-bit Clause-22 frame word per transaction and serializes it MSB first.
- For read frames it releases the bus at turnaround, samples 16 data bits from MDIO_IN, and presents them as a parallel word.

Parameters:
- CLK_DIV, 4: MDC period in CLK cycles; must be even and >= 2.

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous reset, active-low
- T_DATA  in  32  frame word: [31:30] ST, [29:28] OP, [27:23] PHYAD, [22:18] REGAD, [17:16] TA, [15:0] DATA
- T_STRB  in  1  one-CLK request strobe; T_DATA is valid in that cycle
- MDIO_IN  in  1  serial data from PHY (read data phase)
- MDC  out  1  management clock
- MDIO_OUT  out  1  serial data to PHY
- MDIO_OE  out  1  1 = controller drives MDIO
- RD_DATA  out  16  captured read data
- DATA_RDY  out  1  one-CLK pulse when RD_DATA is updated
- BUSY  out  1  transaction in progress

Behaviour:
- Reset (RESET=0, asynchronous): all outputs 0; divider 0; state IDLE. Takes effect immediately, including mid-frame.
- MDC generation:
  - Divider counts 0..CLK_DIV-1 continuously; MDC=1 while count >= CLK_DIV/2.
  - FALL event = count wraps to 0; RISE event = count reaches CLK_DIV/2.
  - MDC is free-running, including in IDLE.
- Transaction request:
  - T_STRB is accepted only in IDLE. T_DATA is latched into a 32-bit shift register and BUSY=1 from the next CLK.
  - T_STRB while BUSY is ignored; no queueing.
- Bit timing:
  - MDIO_OUT/MDIO_OE update only on FALL events, so they are stable at each RISE, where the PHY samples.
  - MDIO_IN is sampled on RISE events.
- States:
  - IDLE: MDIO_OE=0, MDIO_OUT=0. Accept T_STRB -> SEND.
  - SEND: at each FALL, drive shift[31], set MDIO_OE=1, then shift left; bit counter counts 0..31.
    - Read (OP=2'b10): after bit 13 (REGAD LSB) has been driven for a full MDC period, the next FALL sets MDIO_OE=0 and MDIO_OUT=0 -> TURN.
    - Any other OP (write 01, and illegal 00/11 treated as write): all 32 bits are driven. At the FALL after bit 31: MDIO_OE=0 -> DONE.
  - TURN: two MDC periods with MDIO_OE=0 (TA bits); MDIO_IN is not sampled -> READ.
  - READ: 16 RISE events; shift MDIO_IN into RD_DATA MSB first (first sampled bit -> RD_DATA[15]). After the 16th sample, RD_DATA updates and DATA_RDY=1 for exactly one CLK -> DONE.
  - DONE: BUSY=0 on the next CLK -> IDLE. The earliest new T_STRB is accepted in the cycle after BUSY falls.
- Latency:
  - First bit appears on the first FALL after acceptance.
  - Write: BUSY high for 32 MDC periods plus up to one period of alignment.
  - Read: DATA_RDY occurs at the 32nd RISE after the first FALL.
- RD_DATA holds its value until the next completed read; it is unchanged by writes.
- Reset mid-operation: no DATA_RDY pulse; RD_DATA cleared to 0.

Optional Feature:
- Macro: MDIO_PREAMBLE_EN.
- Defined: after acceptance, a PREAMBLE state drives 32 consecutive 1s (MDIO_OE=1), one per FALL, before SEND. All frame latencies grow by 32 MDC periods.
- Undefined: no preamble state; SEND starts directly (the PHY receiver must not require a preamble).

Test Plan:
- Write, CLK_DIV=4: T_STRB with T_DATA=32'h5A5AFF01 (OP=01) -> MDIO_OUT reproduces bits 31..0 on 32 consecutive MDC rises, MDIO_OE=1 throughout, BUSY high about 128 CLK, no DATA_RDY.
- Read: T_DATA=32'h6A5A0000 (OP=10), bench drives MDIO_IN with 16'h8FF1 after TA -> MDIO_OE=1 for 14 bits, then 0 for 18 bits; RD_DATA=16'h8FF1 with a single DATA_RDY pulse.
- Strobe while busy: second T_STRB with 32'h5FFFFFFF mid-write -> ignored, serial stream matches the first frame only.
- Reset mid-read: RESET=0 after 20 MDC periods -> all outputs 0 immediately, no DATA_RDY; after RESET=1 a new write completes normally.
- Back-to-back: read then write issued one CLK after BUSY falls -> both frames correct, RD_DATA retains read value through the write.
- With MDIO_PREAMBLE_EN: write -> 32 ones precede ST=01, total 64 MDC periods.
